imm_pack: RTL and testbench

//   Inverse of the immediate extender: packs a 32-bit signed immediate into the
//   I/S/B/J bit positions of an RV32I instruction word. Checks range/alignment,

---
 rtl/imm_pack.sv | 148 ++++++++++++++
 tb/tb_imm_pack.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_pack.sv
// Purpose: packs a signed immediate into RV32I I/S/B/J fields, flags range/alignment errors, stamps byte addresses.
// Latency: 2 cycles from accept to out_valid with no stall; one word per cycle sustained.
// Backpressure: valid/ready on both sides; stages hold contents while stalled, in_ready drops only when both stages are full.
module imm_pack #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    ERR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            imm_type,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [DATA_WIDTH-1:0] base_instr,
  input  logic                  addr_clear,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_err,
  output logic [ERR_CNT_W-1:0]  err_count
);

  // Immediate type codes, same encoding as the decoder's ImmSrc.
  localparam logic [1:0] T_I = 2'b00;
  localparam logic [1:0] T_S = 2'b01;
  localparam logic [1:0] T_B = 2'b10;
  localparam logic [1:0] T_J = 2'b11;

  // Legal immediate ranges (B and J are byte offsets, so the top is one below even).
  localparam logic signed [DATA_WIDTH-1:0] IS_MIN = -2048;
  localparam logic signed [DATA_WIDTH-1:0] IS_MAX = 2047;
  localparam logic signed [DATA_WIDTH-1:0] B_MIN  = -4096;
  localparam logic signed [DATA_WIDTH-1:0] B_MAX  = 4094;
  localparam logic signed [DATA_WIDTH-1:0] J_MIN  = -(1 << 20);
  localparam logic signed [DATA_WIDTH-1:0] J_MAX  = (1 << 20) - 2;

  logic                  v1;
  logic                  v2;
  logic                  rdy1;
  logic                  rdy2;
  logic                  xfer;
  logic [1:0]            s1_type;
  logic [20:0]           s1_imm;      // only bits that can land in a field are kept
  logic [DATA_WIDTH-1:0] s1_base;
  logic                  s1_err;
  logic                  in_err;
  logic signed [DATA_WIDTH-1:0] simm;
  logic [20:0]           fimm;
  logic [DATA_WIDTH-1:0] packed_word;
  logic [ADDR_WIDTH-1:0] addr_q;

  assign rdy2      = !v2 || out_ready;
  assign rdy1      = !v1 || rdy2;
  assign in_ready  = rdy1;
  assign out_valid = v2;
  assign out_addr  = addr_q;
  assign xfer      = v2 && out_ready;
  assign simm      = $signed(imm);

  // Range and alignment check on the incoming request, captured with it in stage 1.
  always_comb begin
    in_err = 1'b0;
    unique case (imm_type)
      T_I, T_S: in_err = (simm < IS_MIN) || (simm > IS_MAX);
      T_B:      in_err = (simm < B_MIN) || (simm > B_MAX) || imm[0];
      T_J:      in_err = (simm < J_MIN) || (simm > J_MAX) || imm[0];
      default:  in_err = 1'b0;
    endcase
  end

  // Scatter the stage-1 immediate into its field; an erroneous word gets an all-zero field.
  always_comb begin
    fimm        = s1_err ? '0 : s1_imm;
    packed_word = s1_base;
    unique case (s1_type)
      T_I: packed_word[31:20] = fimm[11:0];
      T_S: begin
        packed_word[31:25] = fimm[11:5];
        packed_word[11:7]  = fimm[4:0];
      end
      T_B: begin
        packed_word[31]    = fimm[12];
        packed_word[30:25] = fimm[10:5];
        packed_word[11:8]  = fimm[4:1];
        packed_word[7]     = fimm[11];
      end
      T_J: begin
        packed_word[31]    = fimm[20];
        packed_word[30:21] = fimm[10:1];
        packed_word[20]    = fimm[11];
        packed_word[19:12] = fimm[19:12];
      end
      default: packed_word = s1_base;
    endcase
  end

  // Stage 1: register the request and its error flag whenever the stage can advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else if (rdy1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_type <= imm_type;
        s1_imm  <= imm[20:0];
        s1_base <= base_instr;
        s1_err  <= in_err;
      end
    end
  end

  // Stage 2: register the packed word; held unchanged while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2        <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
    end else if (rdy2) begin
      v2 <= v1;
      if (v1) begin
        out_instr <= packed_word;
        out_err   <= s1_err;
      end
    end
  end

  // Byte address of the word in stage 2; a clear overrides a same-cycle advance.
  always_ff @(posedge clk) begin
    if (rst || addr_clear) begin
      addr_q <= BASE_ADDR;
    end else if (xfer) begin
      addr_q <= addr_q + ADDR_WIDTH'(4);
    end
  end

  // Saturating count of delivered words that carried an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (xfer && out_err && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_pack.sv
// Bench for imm_pack: directed vectors, queue-based reference model checked every cycle.
// A second instance with a 4-bit address shares all inputs to exercise address wrap.
// Literal expectations pin both the model and key DUT cycles.
module tb_imm_pack;
  logic        clk = 1'b0;
  logic        rst, in_valid, addr_clear, out_ready;
  logic [1:0]  imm_type;
  logic [31:0] imm, base_instr;
  logic        in_ready, out_valid, out_err;
  logic [31:0] out_instr, out_addr;
  logic [7:0]  err_count;
  logic        s_in_ready, s_out_valid, s_out_err;
  logic [31:0] s_out_instr;
  logic [3:0]  s_out_addr;
  logic [7:0]  s_err_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imm_pack dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .imm_type(imm_type), .imm(imm), .base_instr(base_instr), .addr_clear(addr_clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
  );

  imm_pack #(.ADDR_WIDTH(4)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .imm_type(imm_type), .imm(imm), .base_instr(base_instr), .addr_clear(addr_clear),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_instr(s_out_instr),
    .out_addr(s_out_addr), .out_err(s_out_err), .err_count(s_err_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference rules: legal ranges as plain integer comparisons.
  function automatic logic exp_err(input logic [1:0] t, input logic [31:0] v);
    int s;
    s = v;
    case (t)
      2'd0, 2'd1: return (s < -2048) || (s > 2047);
      2'd2:       return (s < -4096) || (s > 4094) || v[0];
      default:    return (s < -(1 << 20)) || (s > (1 << 20) - 2) || v[0];
    endcase
  endfunction

  // Reference packing: field mask plus the field value, field zeroed on error.
  function automatic logic [31:0] exp_pack(input logic [1:0] t, input logic [31:0] v, input logic [31:0] b);
    logic [31:0] m, f;
    case (t)
      2'd0: begin m = 32'hFFF0_0000; f = {v[11:0], 20'd0}; end
      2'd1: begin m = 32'hFE00_0F80; f = {v[11:5], 13'd0, v[4:0], 7'd0}; end
      2'd2: begin m = 32'hFE00_0F80; f = {v[12], v[10:5], 13'd0, v[4:1], v[11], 7'd0}; end
      default: begin m = 32'hFFFF_F000; f = {v[20], v[10:1], v[11], v[19:12], 12'd0}; end
    endcase
    return (b & ~m) | (exp_err(t, v) ? 32'd0 : f);
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic        err;
    int          vis;   // edge count at which the word is first presented
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_addr;
  int          m_errs;
  int          ecnt = 0;
  bit          started = 0;

  // Model: words in flight in arrival order; at most two fit in the pipe.
  always @(posedge clk) begin : model
    bit   hv, rdy, xf;
    ent_t e;
    ecnt++;
    if (rst) begin
      q.delete();
      m_addr  = 32'd0;
      m_errs  = 0;
      started = 1;
    end else begin
      hv  = (q.size() > 0) && (q[0].vis <= ecnt - 1);
      rdy = !((q.size() == 2) && !out_ready);
      xf  = hv && out_ready;
      if (xf) begin
        if (q[0].err && m_errs < 255) m_errs++;
        void'(q.pop_front());
        m_addr = m_addr + 32'd4;
        if (q.size() > 0 && q[0].vis < ecnt) q[0].vis = ecnt;
      end
      if (addr_clear) m_addr = 32'd0;
      if (in_valid && rdy) begin
        e.err   = exp_err(imm_type, imm);
        e.instr = exp_pack(imm_type, imm, base_instr);
        e.vis   = ecnt + 1;
        q.push_back(e);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : compare
    bit ev;
    if (started) begin
      ev = (q.size() > 0) && (q[0].vis <= ecnt);
      chk("out_valid", out_valid, ev);
      chk("in_ready", in_ready, !((q.size() == 2) && !out_ready));
      chk("out_addr", out_addr, m_addr);
      chk("err_count", err_count, m_errs);
      chk("small_valid", s_out_valid, ev);
      chk("small_addr", s_out_addr, m_addr[3:0]);
      if (ev) begin
        chk("out_instr", out_instr, q[0].instr);
        chk("out_err", out_err, q[0].err);
      end
    end
  end

  logic [1:0]  vt[16];
  logic [31:0] vi[16];
  logic [31:0] vb[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] t, input logic [31:0] v, input logic [31:0] b);
    in_valid   = 1'b1;
    imm_type   = t;
    imm        = v;
    base_instr = b;
  endtask

  // Stream n table entries, holding out_ready low for cycles lo..hi.
  task automatic run_stream(input int n, input int lo, input int hi, input int cycles,
                            output bit saw, output int acc_n);
    int idx;
    bit acc;
    idx = 0;
    saw = 0;
    for (int c = 0; c < cycles; c++) begin
      in_valid = (idx < n);
      if (idx < n) begin
        imm_type   = vt[idx];
        imm        = vi[idx];
        base_instr = vb[idx];
      end
      out_ready = !(c >= lo && c <= hi);
      #1;
      if (!in_ready) saw = 1;
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    acc_n     = idx;
  endtask

  initial begin
    bit saw;
    int nacc;
    rst = 1'b1; in_valid = 1'b0; imm_type = 2'd0; imm = 32'd0; base_instr = 32'd0;
    addr_clear = 1'b0; out_ready = 1'b1;

    // Pin the model with hand-computed encodings.
    chk("model_I_m1", exp_pack(2'd0, 32'hFFFF_FFFF, 32'h0000_0093), 32'hFFF0_0093);
    chk("model_J_min", exp_pack(2'd3, 32'hFFF0_0000, 32'h0000_006F), 32'h8000_006F);
    chk("model_B_min", exp_pack(2'd2, 32'hFFFF_F000, 32'h0000_0063), 32'h8000_0063);
    chk("model_B_max", exp_pack(2'd2, 32'h0000_0FFE, 32'h0000_0063), 32'h7E00_0FE3);
    chk("model_S_err", exp_pack(2'd1, 32'h0000_0800, 32'h0000_2023), 32'h0000_2023);
    chk("model_err_B3", exp_err(2'd2, 32'd3), 1'b1);
    chk("model_err_Jtop", exp_err(2'd3, 32'h000F_FFFE), 1'b0);
    chk("model_err_Jover", exp_err(2'd3, 32'h0010_0000), 1'b1);

    tick(); tick();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_err", out_err, 1'b0);
    chk("rst_addr", out_addr, 32'd0);
    chk("rst_errcnt", err_count, 8'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;

    // I-type, imm=-1: presented two cycles after acceptance.
    put(2'd0, 32'hFFFF_FFFF, 32'h0000_0093);
    tick();
    in_valid = 1'b0;
    tick();
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_instr", out_instr, 32'hFFF0_0093);
    chk("t1_err", out_err, 1'b0);
    chk("t1_addr", out_addr, 32'd0);
    tick();

    // S out of range, B misaligned, J at its minimum.
    put(2'd1, 32'h0000_0800, 32'h0000_2023);
    tick();
    put(2'd2, 32'd3, 32'h0000_0063);
    tick();
    chk("t2_S_instr", out_instr, 32'h0000_2023);
    chk("t2_S_err", out_err, 1'b1);
    put(2'd3, 32'hFFF0_0000, 32'h0000_006F);
    tick();
    chk("t2_B_err", out_err, 1'b1);
    chk("t2_cnt1", err_count, 8'd1);
    chk("t2_B_addr", out_addr, 32'd8);
    in_valid = 1'b0;
    tick();
    chk("t2_J_instr", out_instr, 32'h8000_006F);
    chk("t2_J_err", out_err, 1'b0);
    chk("t2_cnt2", err_count, 8'd2);
    tick();

    addr_clear = 1'b1;
    tick();
    addr_clear = 1'b0;
    chk("clear_addr", out_addr, 32'd0);

    // Four B words with a three-cycle consumer stall mid-stream.
    vt[0] = 2'd2; vi[0] = 32'd8;          vb[0] = 32'h0020_8463;
    vt[1] = 2'd2; vi[1] = 32'hFFFF_FFF0;  vb[1] = 32'h0020_9063;
    vt[2] = 2'd2; vi[2] = 32'd4094;       vb[2] = 32'h0000_0063;
    vt[3] = 2'd2; vi[3] = 32'hFFFF_F000;  vb[3] = 32'h0000_0063;
    run_stream(4, 2, 4, 15, saw, nacc);
    chk("t3_stall_seen", saw, 1'b1);
    chk("t3_accepted", nacc, 4);
    chk("t3_end_addr", out_addr, 32'd16);
    chk("t3_wrap_addr", s_out_addr, 4'd0);
    chk("t3_drained", out_valid, 1'b0);

    // Clear coinciding with the transfer at address 8.
    addr_clear = 1'b1;
    tick();
    addr_clear = 1'b0;
    put(2'd0, 32'd1, 32'h0000_0013); tick();
    put(2'd0, 32'd2, 32'h0000_0013); tick();
    put(2'd0, 32'd3, 32'h0000_0013); tick();
    put(2'd0, 32'd4, 32'h0000_0013); tick();
    chk("t4_pre_addr", out_addr, 32'd8);
    in_valid   = 1'b0;
    addr_clear = 1'b1;
    tick();
    addr_clear = 1'b0;
    chk("t4_valid", out_valid, 1'b1);
    chk("t4_addr", out_addr, 32'd0);
    chk("t4_instr", out_instr, 32'h0040_0013);
    tick();

    // Reset with both stages full.
    out_ready = 1'b0;
    put(2'd0, 32'd5, 32'h0000_0013); tick();
    put(2'd0, 32'd6, 32'h0000_0013); tick();
    in_valid = 1'b0;
    #1;
    chk("t6_full_in_ready", in_ready, 1'b0);
    chk("t6_full_valid", out_valid, 1'b1);
    rst = 1'b1;
    tick();
    chk("t6_valid", out_valid, 1'b0);
    chk("t6_in_ready", in_ready, 1'b1);
    chk("t6_addr", out_addr, 32'd0);
    chk("t6_errcnt", err_count, 8'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();

    // Range/alignment boundaries for every type.
    vt[0]  = 2'd0; vi[0]  = 32'd2047;       vb[0]  = 32'h0000_0013;
    vt[1]  = 2'd0; vi[1]  = 32'hFFFF_F800;  vb[1]  = 32'h0000_0013;
    vt[2]  = 2'd0; vi[2]  = 32'hFFFF_F7FF;  vb[2]  = 32'h0000_0013;
    vt[3]  = 2'd1; vi[3]  = 32'hFFFF_F800;  vb[3]  = 32'h0000_0023;
    vt[4]  = 2'd1; vi[4]  = 32'd2047;       vb[4]  = 32'h0000_0023;
    vt[5]  = 2'd2; vi[5]  = 32'd4094;       vb[5]  = 32'h0000_0063;
    vt[6]  = 2'd2; vi[6]  = 32'd4096;       vb[6]  = 32'h0000_0063;
    vt[7]  = 2'd2; vi[7]  = 32'hFFFF_EFFE;  vb[7]  = 32'h0000_0063;
    vt[8]  = 2'd3; vi[8]  = 32'h000F_FFFE;  vb[8]  = 32'h0000_00EF;
    vt[9]  = 2'd3; vi[9]  = 32'h0010_0000;  vb[9]  = 32'h0000_00EF;
    vt[10] = 2'd3; vi[10] = 32'hFFEF_FFFE;  vb[10] = 32'h0000_006F;
    vt[11] = 2'd3; vi[11] = 32'd6;          vb[11] = 32'h0000_006F;
    vt[12] = 2'd3; vi[12] = 32'd5;          vb[12] = 32'h0000_006F;
    run_stream(13, 5, 6, 24, saw, nacc);
    chk("bnd_accepted", nacc, 13);
    chk("bnd_errcnt", err_count, 8'd6);

    // Error counter saturation.
    put(2'd1, 32'd5000, 32'h0000_0023);
    for (int i = 0; i < 260; i++) tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("sat_errcnt", err_count, 8'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
